uart_byte_tx: RTL and testbench

Serial transmitter at the far end of the byte handshake used by the message printers (`tx_data` / `new_tx_data` / `tx_busy`). It accepts one byte per handshake and serializes it onto the UART TX pin as 8N1, LSB first, at a fixed baud set by a clock-division parameter. It owns `tx_busy`, which is how upstream printers pace themselves. A `block` input lets a host-side flow-control signal hold off new bytes.

---
 rtl/uart_byte_tx.sv | 116 +++++++++++
 tb/tb_uart_byte_tx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 UART byte transmitter with busy/block flow control
//
// Purpose: accepts one byte per tx_data/new_tx_data handshake and shifts it
// onto tx as start bit, 8 data bits (LSB first), stop bit. Each bit is held
// for CLK_PER_BIT clock cycles.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   tx          out  serial line, idles high, registered
//   block       in   flow control; high holds off new frames (registered once)
//   tx_busy     out  high when a byte cannot be accepted
//   tx_data     in   byte to send, sampled on acceptance only
//   new_tx_data in   one-cycle request, honoured only while tx_busy is low

module uart_byte_tx #(
  parameter int CLK_PER_BIT = 50,
  parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tx,
  input  logic       block,
  output logic       tx_busy,
  input  logic [7:0] tx_data,
  input  logic       new_tx_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [CTR_SIZE-1:0] CTR_LAST = CTR_SIZE'(CLK_PER_BIT - 1);

  state_t              state_q;
  logic [CTR_SIZE-1:0] ctr_q;
  logic [2:0]          bit_q;
  logic [7:0]          data_q;
  logic                tx_q;
  logic                block_q;

  // Busy depends only on registers, so an upstream printer may drive
  // new_tx_data directly from !tx_busy without forming a loop.
  assign tx_busy = (state_q != IDLE) | block_q;
  assign tx      = tx_q;

  // tx_q is always loaded with the level of the state being entered, so the
  // line changes on the same edge as state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      bit_q   <= 3'd0;
      data_q  <= 8'd0;
      tx_q    <= 1'b1;
      block_q <= 1'b0;
    end else begin
      block_q <= block;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!block_q && new_tx_data) begin
            data_q  <= tx_data;
            ctr_q   <= '0;
            bit_q   <= 3'd0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (ctr_q == CTR_LAST) begin
            ctr_q   <= '0;
            tx_q    <= data_q[0];
            state_q <= DATA;
          end else begin
            ctr_q <= ctr_q + CTR_SIZE'(1);
          end
        end
        DATA: begin
          if (ctr_q == CTR_LAST) begin
            ctr_q <= '0;
            if (bit_q == 3'd7) begin
              bit_q   <= 3'd0;
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= data_q[bit_q + 3'd1];
            end
          end else begin
            ctr_q <= ctr_q + CTR_SIZE'(1);
          end
        end
        STOP: begin
          if (ctr_q == CTR_LAST) begin
            ctr_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= IDLE;
          end else begin
            ctr_q <= ctr_q + CTR_SIZE'(1);
          end
        end
        default: begin
          ctr_q   <= '0;
          bit_q   <= 3'd0;
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb/tb_uart_byte_tx.sv - directed self-checking bench for uart_byte_tx

module tb_uart_byte_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx;
  logic       block = 1'b0;
  logic       tx_busy;
  logic [7:0] tx_data = 8'h00;
  logic       new_tx_data = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic pulse_en = 1'b0;
  logic blk_en   = 1'b0;

  uart_byte_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx          (tx),
    .block       (block),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // All driving and sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns in the first cycle of the frame.
  task automatic request(input logic [7:0] b);
    tx_data     = b;
    new_tx_data = 1'b1;
    tick();
    new_tx_data = 1'b0;
    tx_data     = ~b ^ 8'h3C;
  endtask

  // Check nbits bit-periods of the frame for byte b; with nbits == 10 also
  // checks the cycle after the stop bit (tx high, tx_busy == busy_end).
  task automatic frame(input logic [7:0] b, input int nbits, input logic busy_end);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      for (int j = 0; j < CPB; j++) begin
        check($sformatf("tx_bit%0d_c%0d", i, j), tx, fr[i]);
        check($sformatf("busy_bit%0d_c%0d", i, j), tx_busy, 1'b1);
        if (pulse_en && i == 5 && j == 0) new_tx_data = 1'b1;
        if (blk_en && i == 3 && j == 0) block = 1'b1;
        tick();
        new_tx_data = 1'b0;
      end
    end
    if (nbits == 10) begin
      check("tx_after_stop", tx, 1'b1);
      check("busy_after_stop", tx_busy, busy_end);
    end
  endtask

  task automatic idle_for(input int n, input logic busy_exp);
    for (int k = 0; k < n; k++) begin
      check("idle_tx", tx, 1'b1);
      check("idle_busy", tx_busy, busy_exp);
      tick();
    end
  endtask

  initial begin
    // Reset held 3 cycles with a request pending.
    rst = 1'b1;
    new_tx_data = 1'b1;
    tx_data = 8'h55;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_tx", tx, 1'b1);
      check("rst_busy", tx_busy, 1'b0);
    end
    rst = 1'b0;
    new_tx_data = 1'b0;
    tick();
    check("post_rst_tx", tx, 1'b1);
    check("post_rst_busy", tx_busy, 1'b0);
    idle_for(6, 1'b0);

    // Single bytes, with tx_data scrambled right after acceptance.
    request(8'h55); frame(8'h55, 10, 1'b0);
    idle_for(3, 1'b0);
    request(8'h00); frame(8'h00, 10, 1'b0);
    request(8'hFF); frame(8'hFF, 10, 1'b0);

    // Back-to-back "h","i": request issued in the single idle cycle; a pulse
    // mid-frame of "h" must be dropped.
    idle_for(2, 1'b0);
    pulse_en = 1'b1;
    request(8'h68); frame(8'h68, 10, 1'b0);
    pulse_en = 1'b0;
    request(8'h69); frame(8'h69, 10, 1'b0);
    idle_for(12, 1'b0);

    // Block before request: request ignored.
    block = 1'b1;
    tick();
    check("blk_busy", tx_busy, 1'b1);
    tx_data = 8'h12;
    new_tx_data = 1'b1;
    tick();
    new_tx_data = 1'b0;
    idle_for(10, 1'b1);
    block = 1'b0;
    check("blk_fall_busy_same", tx_busy, 1'b1);
    tick();
    check("blk_fall_busy_next", tx_busy, 1'b0);
    idle_for(6, 1'b0);

    // Block raised mid-frame: frame completes, busy held until block drops.
    blk_en = 1'b1;
    request(8'h81); frame(8'h81, 10, 1'b1);
    blk_en = 1'b0;
    idle_for(3, 1'b1);
    block = 1'b0;
    check("midblk_busy_same", tx_busy, 1'b1);
    tick();
    check("midblk_busy_next", tx_busy, 1'b0);
    idle_for(3, 1'b0);

    // Reset during data bit 3 of 0xA5, then a clean 0x3C frame.
    request(8'hA5); frame(8'hA5, 4, 1'b1);
    check("abort_bit3_tx", tx, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", tx_busy, 1'b0);
    idle_for(45, 1'b0);
    request(8'h3C); frame(8'h3C, 10, 1'b0);
    idle_for(4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
